parking_gate_ctrl_param: RTL and testbench

Parametrised next-generation parking-gate controller.
- Handles N_DIGITS-digit BCD PINs and a configurable attempt limit.
- Adds a PIN-entry timeout, lot occupancy tracking with a full flag, an exit decrement input, and a tailgate/blocked recovery path.
- Sits between the entry sensors/keypad and the gate actuator; the tester drives all inputs through its ports.

---
 rtl/parking_pkg.sv | 21 ++
 rtl/pin_checker.sv | 23 ++
 rtl/parking_gate_ctrl_param.sv | 151 +++++++++++++++
 tb/tb_parking_gate_ctrl_param.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking-gate controller: FSM state encoding,
// default parameter values and the BCD digit check used by the PIN comparator.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PIN = 2'd1,
    OPEN     = 2'd2,
    BLOCKED  = 2'd3
  } state_e;

  localparam int DEF_N_DIGITS     = 4;
  localparam int DEF_MAX_ATTEMPTS = 3;
  localparam int DEF_PIN_TIMEOUT  = 16;
  localparam int DEF_CAPACITY     = 8;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/pin_checker.sv
// Combinational PIN comparator: accepts an entry only if every nibble is a valid
// BCD digit and the whole entry matches the stored PIN.
module pin_checker
  import parking_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS
) (
  input  logic [4*N_DIGITS-1:0] pin,
  input  logic [4*N_DIGITS-1:0] stored_pin,
  output logic                  pin_ok
);

  logic all_bcd;

  always_comb begin
    all_bcd = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      all_bcd = all_bcd & is_bcd(pin[4*i +: 4]);
    end
    pin_ok = all_bcd && (pin == stored_pin);
  end

endmodule

// File: rtl/parking_gate_ctrl_param.sv
// Parking-gate controller: PIN-gated entry FSM with attempt limit, entry timeout,
// tailgate detection and lot occupancy tracking. All outputs are registered.
module parking_gate_ctrl_param
  import parking_pkg::*;
#(
  parameter  int N_DIGITS     = DEF_N_DIGITS,
  parameter  int MAX_ATTEMPTS = DEF_MAX_ATTEMPTS,
  parameter  int PIN_TIMEOUT  = DEF_PIN_TIMEOUT,
  parameter  int CAPACITY     = DEF_CAPACITY,
  localparam int OCC_W        = $clog2(CAPACITY + 1),
  localparam int ATT_W        = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sensor_vehicule,
  input  logic                  sensor_moved_vehicule,
  input  logic [4*N_DIGITS-1:0] password_input,
  input  logic                  password_valid,
  input  logic [4*N_DIGITS-1:0] correct_password,
  input  logic                  vehicle_exit,
  output logic                  open_gate,
  output logic                  close_gate,
  output logic                  alarm_wrong_pin,
  output logic                  alarm_blocked,
  output logic                  lot_full,
  output logic [OCC_W-1:0]      occupancy,
  output logic [ATT_W-1:0]      attempts
);

  localparam int               TMR_W    = $clog2(PIN_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PIN_TIMEOUT - 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(CAPACITY);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ATT_W-1:0]   attempts_q, attempts_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               alarm_wrong_q, alarm_wrong_d;
  logic               alarm_blocked_q, alarm_blocked_d;
  logic               open_gate_q, open_gate_d;
  logic               close_gate_q, close_gate_d;
  logic               lot_full_q, lot_full_d;
  logic               entry_inc;
  logic               pin_ok;

  pin_checker #(
    .N_DIGITS (N_DIGITS)
  ) u_pin_checker (
    .pin        (password_input),
    .stored_pin (correct_password),
    .pin_ok     (pin_ok)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    attempts_d    = attempts_q;
    alarm_wrong_d = alarm_wrong_q;
    entry_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (sensor_vehicule && !sensor_moved_vehicule && (occ_q < OCC_MAX)) begin
          state_d = WAIT_PIN;
          timer_d = '0;
        end
      end
      WAIT_PIN: begin
        timer_d = timer_q + 1'b1;
        // A strobe in the same cycle wins over both timeout and sensor drop.
        if (password_valid) begin
          if (pin_ok) begin
            state_d       = OPEN;
            attempts_d    = '0;
            alarm_wrong_d = 1'b0;
          end else begin
            attempts_d    = attempts_q + 1'b1;
            alarm_wrong_d = 1'b1;
            timer_d       = '0;
            if (attempts_d == ATT_MAX) begin
              state_d = BLOCKED;
            end
          end
        end else if ((timer_q == TMR_LAST) || !sensor_vehicule) begin
          state_d = IDLE;
        end
      end
      OPEN: begin
        // Both sensors at once means a second car is tailgating the first.
        if (sensor_moved_vehicule) begin
          entry_inc = 1'b1;
          state_d   = sensor_vehicule ? BLOCKED : IDLE;
        end
      end
      BLOCKED: begin
        if (password_valid && pin_ok) begin
          state_d       = IDLE;
          attempts_d    = '0;
          alarm_wrong_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    occ_d = occ_q;
    if (entry_inc && !vehicle_exit) begin
      occ_d = occ_q + 1'b1;
    end else if (!entry_inc && vehicle_exit && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end

    open_gate_d     = (state_d == OPEN);
    close_gate_d    = ~open_gate_d;
    alarm_blocked_d = (state_d == BLOCKED);
    lot_full_d      = (occ_d == OCC_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      attempts_q      <= '0;
      occ_q           <= '0;
      alarm_wrong_q   <= 1'b0;
      alarm_blocked_q <= 1'b0;
      open_gate_q     <= 1'b0;
      close_gate_q    <= 1'b1;
      lot_full_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      attempts_q      <= attempts_d;
      occ_q           <= occ_d;
      alarm_wrong_q   <= alarm_wrong_d;
      alarm_blocked_q <= alarm_blocked_d;
      open_gate_q     <= open_gate_d;
      close_gate_q    <= close_gate_d;
      lot_full_q      <= lot_full_d;
    end
  end

  assign open_gate       = open_gate_q;
  assign close_gate      = close_gate_q;
  assign alarm_wrong_pin = alarm_wrong_q;
  assign alarm_blocked   = alarm_blocked_q;
  assign lot_full        = lot_full_q;
  assign occupancy       = occ_q;
  assign attempts        = attempts_q;

endmodule

// File: tb/tb_parking_gate_ctrl_param.sv
// Directed bench for parking_gate_ctrl_param: each step queues the expected
// registered outputs and checks them one edge later against the DUT.
module tb_parking_gate_ctrl_param;

  localparam logic [15:0] PIN = 16'h3761;

  logic        clk = 1'b0;
  logic        rst;
  logic        sensor_vehicule;
  logic        sensor_moved_vehicule;
  logic [15:0] password_input;
  logic        password_valid;
  logic [15:0] correct_password;
  logic        vehicle_exit;
  logic        open_gate;
  logic        close_gate;
  logic        alarm_wrong_pin;
  logic        alarm_blocked;
  logic        lot_full;
  logic [3:0]  occupancy;
  logic [1:0]  attempts;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  tests  = 0;
  int  failed = 0;

  parking_gate_ctrl_param dut (
    .clk                   (clk),
    .rst                   (rst),
    .sensor_vehicule       (sensor_vehicule),
    .sensor_moved_vehicule (sensor_moved_vehicule),
    .password_input        (password_input),
    .password_valid        (password_valid),
    .correct_password      (correct_password),
    .vehicle_exit          (vehicle_exit),
    .open_gate             (open_gate),
    .close_gate            (close_gate),
    .alarm_wrong_pin       (alarm_wrong_pin),
    .alarm_blocked         (alarm_blocked),
    .lot_full              (lot_full),
    .occupancy             (occupancy),
    .attempts              (attempts)
  );

  always #5 clk = ~clk;

  // Expected output vector: {open, close, alarm_wrong, alarm_blocked, full, occ, att}
  function automatic logic [10:0] S(input logic o, input logic aw, input logic ab,
                                    input logic f, input int occ, input int att);
    return {o, ~o, aw, ab, f, 4'(occ), 2'(att)};
  endfunction

  task automatic step(input string tag, input logic sv, input logic sm,
                      input logic pv, input logic [15:0] pin, input logic ex,
                      input logic [10:0] e);
    sb_t         item;
    logic [10:0] obs;
    sensor_vehicule       = sv;
    sensor_moved_vehicule = sm;
    password_valid        = pv;
    password_input        = pin;
    vehicle_exit          = ex;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    obs  = {open_gate, close_gate, alarm_wrong_pin, alarm_blocked, lot_full,
            occupancy, attempts};
    tests++;
    assert (obs === item.exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
    end
  endtask

  initial begin
    correct_password = PIN;
    rst = 1'b1;
    step("reset0", 1, 0, 0, 16'h0, 0, S(0, 0, 0, 0, 0, 0));
    step("reset1", 1, 0, 1, PIN, 0, S(0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // Correct PIN admits a vehicle
    step("t1_wait", 1, 0, 0, 16'h0, 0, S(0, 0, 0, 0, 0, 0));
    step("t1_open", 1, 0, 1, PIN,   0, S(1, 0, 0, 0, 0, 0));
    step("t1_pass", 0, 1, 0, 16'h0, 0, S(0, 0, 0, 0, 1, 0));
    step("t1_idle", 0, 0, 0, 16'h0, 0, S(0, 0, 0, 0, 1, 0));

    // Two wrong PINs then correct
    step("t2_wait",   1, 0, 0, 16'h0,    0, S(0, 0, 0, 0, 1, 0));
    step("t2_wrong1", 1, 0, 1, 16'h1235, 0, S(0, 1, 0, 0, 1, 1));
    step("t2_wrong2", 1, 0, 1, 16'h1234, 0, S(0, 1, 0, 0, 1, 2));
    step("t2_open",   1, 0, 1, PIN,      0, S(1, 0, 0, 0, 1, 0));
    step("t2_pass",   0, 1, 0, 16'h0,    0, S(0, 0, 0, 0, 2, 0));

    // Three wrong PINs (one non-BCD) block; only the correct PIN releases
    step("t3_wait",    1, 0, 0, 16'h0,    0, S(0, 0, 0, 0, 2, 0));
    step("t3_nonbcd",  1, 0, 1, 16'h37A1, 0, S(0, 1, 0, 0, 2, 1));
    step("t3_wrong2",  1, 0, 1, 16'h0000, 0, S(0, 1, 0, 0, 2, 2));
    step("t3_block",   1, 0, 1, 16'h9999, 0, S(0, 1, 1, 0, 2, 3));
    step("t3_sens1",   1, 0, 0, 16'h0,    0, S(0, 1, 1, 0, 2, 3));
    step("t3_sens2",   1, 1, 0, 16'h0,    0, S(0, 1, 1, 0, 2, 3));
    step("t3_wrongb",  1, 0, 1, 16'h1111, 0, S(0, 1, 1, 0, 2, 3));
    step("t3_release", 0, 0, 1, PIN,      0, S(0, 0, 0, 0, 2, 0));

    // Timeout after 16 idle cycles in WAIT_PIN; attempts retained
    step("t4_wait",  1, 0, 0, 16'h0,    0, S(0, 0, 0, 0, 2, 0));
    step("t4_wrong", 1, 0, 1, 16'h1234, 0, S(0, 1, 0, 0, 2, 1));
    for (int i = 0; i < 16; i++)
      step("t4_tick", 1, 0, 0, 16'h0, 0, S(0, 1, 0, 0, 2, 1));
    step("t4_timed_out", 1, 0, 1, PIN, 0, S(0, 1, 0, 0, 2, 1));
    for (int i = 0; i < 15; i++)
      step("t4_tick2", 1, 0, 0, 16'h0, 0, S(0, 1, 0, 0, 2, 1));
    step("t4_strobe_prio", 1, 0, 1, PIN, 0, S(1, 0, 0, 0, 2, 0));

    // Tailgate from OPEN
    step("t5_tailgate", 1, 1, 0, 16'h0, 0, S(0, 0, 1, 0, 3, 0));
    step("t5_release",  0, 0, 1, PIN,   0, S(0, 0, 0, 0, 3, 0));

    // Fill the lot
    for (int n = 3; n < 8; n++) begin
      step("t6_wait", 1, 0, 0, 16'h0, 0, S(0, 0, 0, 0, n, 0));
      step("t6_open", 1, 0, 1, PIN,   0, S(1, 0, 0, 0, n, 0));
      step("t6_pass", 0, 1, 0, 16'h0, 0, S(0, 0, 0, (n == 7), n + 1, 0));
    end
    step("t6_full_sens", 1, 0, 0, 16'h0, 0, S(0, 0, 0, 1, 8, 0));
    step("t6_full_pin",  1, 0, 1, PIN,   0, S(0, 0, 0, 1, 8, 0));
    step("t6_exit",      0, 0, 0, 16'h0, 1, S(0, 0, 0, 0, 7, 0));
    step("t6_wait7",     1, 0, 0, 16'h0, 0, S(0, 0, 0, 0, 7, 0));
    step("t6_open7",     1, 0, 1, PIN,   0, S(1, 0, 0, 0, 7, 0));
    step("t6_inc_exit",  0, 1, 0, 16'h0, 1, S(0, 0, 0, 0, 7, 0));
    for (int n = 6; n >= 0; n--)
      step("t6_drain", 0, 0, 0, 16'h0, 1, S(0, 0, 0, 0, n, 0));
    step("t6_exit_at0", 0, 0, 0, 16'h0, 1, S(0, 0, 0, 0, 0, 0));

    // Reset mid-operation
    step("t7_wait",  1, 0, 0, 16'h0,    0, S(0, 0, 0, 0, 0, 0));
    step("t7_open",  1, 0, 1, PIN,      0, S(1, 0, 0, 0, 0, 0));
    step("t7_pass",  0, 1, 0, 16'h0,    0, S(0, 0, 0, 0, 1, 0));
    step("t7_wait2", 1, 0, 0, 16'h0,    0, S(0, 0, 0, 0, 1, 0));
    step("t7_wrong", 1, 0, 1, 16'h5555, 0, S(0, 1, 0, 0, 1, 1));
    rst = 1'b1;
    step("t7_reset", 1, 0, 0, 16'h0,    0, S(0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
